// File: rtl/uart_bus_master_if.sv
// Host byte-stream (rx/tx) and single-word memif request/response signals
// for the UART bus master.
interface uart_bus_master_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        memif_req;
  logic        memif_gnt;
  logic        memif_wen;
  logic [3:0]  memif_strb;
  logic [31:0] memif_addr;
  logic [31:0] memif_wdata;
  logic [31:0] memif_rdata;
  logic        memif_error;

  modport master (
    input  rx_valid, rx_data, tx_ready, memif_gnt, memif_rdata, memif_error,
    output rx_ready, tx_valid, tx_data, memif_req, memif_wen, memif_strb,
           memif_addr, memif_wdata
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, memif_gnt, memif_rdata, memif_error,
    input  rx_ready, tx_valid, tx_data, memif_req, memif_wen, memif_strb,
           memif_addr, memif_wdata
  );
endinterface

// File: rtl/uart_bus_master.sv
// Byte-stream bus initiator: parses R/W command frames from the host, issues one
// memif word access per frame and streams back status (and read data).
module uart_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  CMD_RD         = 8'h52,
  parameter logic [7:0]  CMD_WR         = 8'h57
) (
  input  logic               g_clk,
  input  logic               g_reset,
  output logic               g_clk_req,
  output logic               timeout,
  uart_bus_master_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_REQ, S_RSP, S_TX_STAT, S_TX_DATA
  } state_e;

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        is_wr_q, is_wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] tmo_q, tmo_d;
  logic [7:0]  status_q, status_d;
  logic        rx_fire, tx_fire, in_frame;

  // rx_ready/g_clk_req depend on IDLE, so they are forced low while reset is held
  assign bus.rx_ready  = !g_reset && (state_q == S_IDLE || state_q == S_ADDR ||
                                      state_q == S_WDATA);
  assign bus.tx_valid  = (state_q == S_TX_STAT) || (state_q == S_TX_DATA);
  assign bus.tx_data   = (state_q == S_TX_STAT) ? status_q :
                         (state_q == S_TX_DATA) ? rdata_q[7:0] : 8'h00;
  assign bus.memif_req   = (state_q == S_REQ);
  assign bus.memif_wen   = bus.memif_req && is_wr_q;
  assign bus.memif_strb  = {4{bus.memif_req}};
  assign bus.memif_addr  = addr_q;
  assign bus.memif_wdata = wdata_q;
  assign g_clk_req = !g_reset && ((state_q != S_IDLE) || bus.rx_valid);

  assign rx_fire  = bus.rx_valid && bus.rx_ready;
  assign tx_fire  = bus.tx_valid && bus.tx_ready;
  assign in_frame = (state_q == S_ADDR) || (state_q == S_WDATA);
  // An accepted byte on the limit cycle beats the timeout
  assign timeout  = in_frame && !rx_fire && (tmo_q == TMO_LAST);

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      is_wr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      tmo_q    <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      is_wr_q  <= is_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      tmo_q    <= tmo_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    is_wr_d  = is_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    tmo_d    = tmo_q;
    status_d = status_q;
    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        idx_d = '0;
        if (rx_fire) begin
          if (bus.rx_data == CMD_RD || bus.rx_data == CMD_WR) begin
            is_wr_d = (bus.rx_data == CMD_WR);
            state_d = S_ADDR;
          end else begin
            status_d = 8'hFF;
            state_d  = S_TX_STAT;
          end
        end
      end
      S_ADDR, S_WDATA: begin
        if (rx_fire) begin
          tmo_d = '0;
          idx_d = idx_q + 2'd1;
          // Little-endian fields: shift each byte in from the top
          if (state_q == S_ADDR) addr_d  = {bus.rx_data, addr_q[31:8]};
          else                   wdata_d = {bus.rx_data, wdata_q[31:8]};
          if (idx_q == 2'd3) begin
            if (state_q == S_ADDR && is_wr_q) begin
              state_d = S_WDATA;
            end else if (addr_d[1:0] != 2'b00) begin
              status_d = 8'h02;
              state_d  = S_TX_STAT;
            end else begin
              state_d = S_REQ;
            end
          end
        end else if (timeout) begin
          state_d = S_IDLE;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      S_REQ: begin
        if (bus.memif_gnt) state_d = S_RSP;
      end
      S_RSP: begin
        rdata_d  = bus.memif_rdata;
        status_d = bus.memif_error ? 8'h01 : 8'h00;
        state_d  = S_TX_STAT;
      end
      S_TX_STAT: begin
        if (tx_fire) begin
          idx_d   = '0;
          state_d = (!is_wr_q && status_q == 8'h00) ? S_TX_DATA : S_IDLE;
        end
      end
      S_TX_DATA: begin
        if (tx_fire) begin
          rdata_d = {8'h00, rdata_q[31:8]};
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench for uart_bus_master: host frames push expected bus requests
// and response bytes; a bus responder and a tx sink pop and compare them.
module tb_uart_bus_master;
  logic g_clk = 1'b0;
  logic g_reset;
  logic g_clk_req, timeout;

  uart_bus_master_if bus();

  uart_bus_master #(.TIMEOUT_CYCLES(16)) dut (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .g_clk_req (g_clk_req),
    .timeout   (timeout),
    .bus       (bus)
  );

  always #5 g_clk = ~g_clk;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } req_t;

  req_t       exp_req[$];
  logic [7:0] exp_tx[$];
  int n_cmp = 0;
  int n_bad = 0;
  int req_cnt = 0;
  int gnt_delay = 0;
  bit tx_stall = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bus responder: checks each request, holds off gnt, then returns rdata/error
  initial begin
    req_t e;
    int   dly;
    bit   aborted;
    bus.memif_gnt = 1'b0; bus.memif_rdata = '0; bus.memif_error = 1'b0;
    forever begin
      @(negedge g_clk);
      if (bus.memif_req) begin
        req_cnt++;
        e = '{default: '0};
        check("req_expected", 32'(exp_req.size() > 0), 32'd1);
        if (exp_req.size() > 0) e = exp_req.pop_front();
        check("req_addr", bus.memif_addr, e.addr);
        check("req_wen", 32'(bus.memif_wen), 32'(e.wen));
        check("req_strb", 32'(bus.memif_strb), 32'hF);
        if (e.wen) check("req_wdata", bus.memif_wdata, e.wdata);
        dly = gnt_delay;
        aborted = 0;
        for (int k = 0; k < dly; k++) begin
          @(negedge g_clk);
          if (!bus.memif_req) begin aborted = 1; break; end
          check("req_addr_hold", bus.memif_addr, e.addr);
        end
        if (!aborted) begin
          bus.memif_gnt = 1'b1;
          @(negedge g_clk);
          bus.memif_gnt = 1'b0;
          bus.memif_rdata = e.rdata;
          bus.memif_error = e.err;
          check("rsp_req_low", 32'(bus.memif_req), 32'd0);
          @(negedge g_clk);
          bus.memif_rdata = 32'hBAD0BAD0;
          bus.memif_error = 1'b0;
        end
      end
    end
  end

  // Tx sink: optionally stalls 10 cycles per byte, then compares and takes it
  initial begin
    logic [7:0] held;
    bus.tx_ready = 1'b0;
    forever begin
      @(negedge g_clk);
      if (!g_reset && bus.tx_valid) begin
        if (tx_stall) begin
          held = bus.tx_data;
          repeat (10) @(negedge g_clk);
          check("tx_valid_hold", 32'(bus.tx_valid), 32'd1);
          check("tx_data_hold", 32'(bus.tx_data), 32'(held));
        end
        check("tx_expected", 32'(exp_tx.size() > 0), 32'd1);
        if (exp_tx.size() > 0) check("tx_byte", 32'(bus.tx_data), 32'(exp_tx.pop_front()));
        bus.tx_ready = 1'b1;
        @(negedge g_clk);
        bus.tx_ready = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge g_clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (!bus.rx_ready && n < 3000) begin @(negedge g_clk); n++; end
    if (n >= 3000) check("rx_accept_timeout", 32'(n), 32'd0);
    @(posedge g_clk);
  endtask

  task automatic rx_idle();
    #1 bus.rx_valid = 1'b0;
  endtask

  task automatic send_rd(input logic [31:0] a, input logic [31:0] d, input bit err,
                         input bit rsp = 1);
    send_byte(8'h52);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    if (a[1:0] != 2'b00) begin
      exp_tx.push_back(8'h02);
    end else begin
      exp_req.push_back('{addr: a, wen: 1'b0, wdata: '0, rdata: d, err: err});
      if (rsp) begin
        exp_tx.push_back(err ? 8'h01 : 8'h00);
        if (!err) for (int i = 0; i < 4; i++) exp_tx.push_back(d[8*i +: 8]);
      end
    end
  endtask

  task automatic send_wr(input logic [31:0] a, input logic [31:0] w, input bit err);
    send_byte(8'h57);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    if (a[1:0] != 2'b00) begin
      exp_tx.push_back(8'h02);
    end else begin
      exp_req.push_back('{addr: a, wen: 1'b1, wdata: w, rdata: '0, err: err});
      exp_tx.push_back(err ? 8'h01 : 8'h00);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_tx.size() != 0 && n < 2000) begin @(negedge g_clk); n++; end
    repeat (3) @(negedge g_clk);
    check({tag, "_drained"}, 32'(exp_tx.size()), 32'd0);
    check({tag, "_idle"}, 32'(g_clk_req), 32'd0);
  endtask

  initial begin
    int n0, n, hit;
    g_reset = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    repeat (2) @(negedge g_clk);
    check("rst_req", 32'(bus.memif_req), 32'd0);
    check("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_strb", 32'(bus.memif_strb), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_clk_req", 32'(g_clk_req), 32'd0);
    g_reset = 1'b0;
    @(negedge g_clk);
    check("idle_rx_ready", 32'(bus.rx_ready), 32'd1);

    // 1: write, same-cycle grant
    n0 = req_cnt; gnt_delay = 0;
    send_wr(32'h2000_1000, 32'hDEAD_BEEF, 1'b0); rx_idle(); drain("t1");
    check("t1_nreq", 32'(req_cnt - n0), 32'd1);

    // 2: read, grant after 3 cycles
    gnt_delay = 3;
    send_rd(32'h2000_1000, 32'h1234_5678, 1'b0); rx_idle(); drain("t2");

    // 3: read with bus error
    gnt_delay = 1;
    send_rd(32'h0000_0040, 32'hCAFE_F00D, 1'b1); rx_idle(); drain("t3");
    send_wr(32'h0000_0044, 32'h0102_0304, 1'b1); rx_idle(); drain("t3w");

    // 4: misaligned and unknown command, then a normal read
    n0 = req_cnt; gnt_delay = 0;
    send_rd(32'h0000_0002, 32'h0, 1'b0); rx_idle(); drain("t4rd");
    send_wr(32'h0000_0103, 32'h5555_AAAA, 1'b0); rx_idle(); drain("t4wr");
    check("t4_noreq", 32'(req_cnt - n0), 32'd0);
    send_byte(8'h41); exp_tx.push_back(8'hFF); rx_idle(); drain("t4unk");
    send_rd(32'h0000_0100, 32'hA5A5_5A5A, 1'b0); rx_idle(); drain("t4next");

    // 5: inter-byte timeout
    send_byte(8'h52); send_byte(8'h00); rx_idle();
    n = 0; hit = 0;
    for (int k = 1; k <= 40 && hit == 0; k++) begin
      @(negedge g_clk);
      if (timeout) begin hit = 1; n = k; end
    end
    check("t5_tmo_cycle", 32'(n), 32'd16);
    @(negedge g_clk);
    check("t5_tmo_pulse", 32'(timeout), 32'd0);
    check("t5_tmo_idle", 32'(g_clk_req), 32'd0);
    send_rd(32'h0000_0200, 32'h0BAD_F00D, 1'b0); rx_idle(); drain("t5next");

    // 6: slow tx with rx_valid held, then reset during REQ
    tx_stall = 1; gnt_delay = 2;
    send_rd(32'h0000_0300, 32'h1122_3344, 1'b0);
    send_wr(32'h0000_0304, 32'h5566_7788, 1'b0);
    send_rd(32'h0000_0308, 32'h99AA_BBCC, 1'b0);
    rx_idle(); drain("t6slow");
    tx_stall = 0; gnt_delay = 20;
    send_rd(32'h0000_0400, 32'hDEAD_DEAD, 1'b0, 1'b0); rx_idle();
    n = 0;
    while (!bus.memif_req && n < 50) begin @(negedge g_clk); n++; end
    check("t6_req_seen", 32'(bus.memif_req), 32'd1);
    @(negedge g_clk);
    #2 g_reset = 1'b1;
    #1;
    check("t6_rst_req", 32'(bus.memif_req), 32'd0);
    check("t6_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("t6_rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    repeat (2) @(negedge g_clk);
    g_reset = 1'b0; gnt_delay = 0;
    send_rd(32'h0000_0500, 32'hFEED_FACE, 1'b0); rx_idle(); drain("t6after");
    check("reqs_consumed", 32'(exp_req.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
